// File: rtl/sfu_op_scheduler_if.sv
// ----------------------------------------------------------------------------
// sfu_op_scheduler_if
//   Bundles every non-clock/reset signal of the SFU op scheduler.
//   master : the environment (requesters, datapath, response consumer)
//   slave  : the scheduler itself
//   Signals:
//     req_valid/req_opcode/req_x -> req_ready   per-requester request bus
//     issue_valid/issue_opcode/issue_x          op presented to the datapath
//     dp_valid/dp_result                        datapath result
//     resp_valid/resp_id/resp_data/resp_err <- resp_ready   response FIFO
//     busy, err_mismatch                        status
// ----------------------------------------------------------------------------
interface sfu_op_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int X_W     = 24,
    parameter int R_W     = 32
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]     req_valid;
    logic [4*NUM_REQ-1:0]   req_opcode;
    logic [X_W*NUM_REQ-1:0] req_x;
    logic [NUM_REQ-1:0]     req_ready;

    logic                   issue_valid;
    logic [3:0]             issue_opcode;
    logic [X_W-1:0]         issue_x;

    logic                   dp_valid;
    logic [R_W-1:0]         dp_result;

    logic                   resp_valid;
    logic                   resp_ready;
    logic [ID_W-1:0]        resp_id;
    logic [R_W-1:0]         resp_data;
    logic                   resp_err;

    logic                   busy;
    logic                   err_mismatch;

    modport master (
        output req_valid, req_opcode, req_x, dp_valid, dp_result, resp_ready,
        input  req_ready, issue_valid, issue_opcode, issue_x,
               resp_valid, resp_id, resp_data, resp_err, busy, err_mismatch
    );

    modport slave (
        input  req_valid, req_opcode, req_x, dp_valid, dp_result, resp_ready,
        output req_ready, issue_valid, issue_opcode, issue_x,
               resp_valid, resp_id, resp_data, resp_err, busy, err_mismatch
    );
endinterface

// File: rtl/sfu_op_scheduler.sv
// ----------------------------------------------------------------------------
// sfu_op_scheduler
//   Shares one fixed-latency SFU datapath between NUM_REQ requesters.
//   Round-robin arbitration, one issue per cycle, in-flight tracking pipe
//   aligned with the datapath latency, and a credit-protected FWFT response
//   FIFO tagged with the requester id.
//   Ports:
//     clk  - clock
//     rst  - asynchronous active-high reset
//     bus  - sfu_op_scheduler_if.slave (request, issue, datapath, response,
//            status signals)
//   Optional feature macro: SFU_OPCODE_CHECK_EN
//     defined   : opcodes above 8 are accepted but not issued; they return
//                 resp_err=1, resp_data=0 in order.
//     undefined : every opcode is issued; resp_err is always 0.
// ----------------------------------------------------------------------------
module sfu_op_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DP_LAT     = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int X_W        = 24,
    parameter int R_W        = 32
) (
    input logic               clk,
    input logic               rst,
    sfu_op_scheduler_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENT_W = ID_W + R_W + 1;

    // Unpacked views of the packed request buses
    logic [3:0]     req_op [NUM_REQ];
    logic [X_W-1:0] req_x  [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_op[gi] = bus.req_opcode[gi*4 +: 4];
            assign req_x[gi]  = bus.req_x[gi*X_W +: X_W];
        end
    endgenerate

    logic [ID_W-1:0]  ptr_q;
    logic [CNT_W-1:0] inflight_q;
    logic [CNT_W-1:0] fifo_count_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             err_mismatch_q;

    // ---------------- credit check and round-robin arbiter ----------------
    logic [CNT_W:0]       credits_used;
    logic                 can_accept;
    logic                 grant_any;
    logic [ID_W-1:0]      grant_idx;
    logic [ID_W:0]        scan_sum;
    logic                 handshake;
    logic [NUM_REQ-1:0]   req_ready_d;
    logic [3:0]           grant_op;
    logic [X_W-1:0]       grant_x;
    logic                 grant_illegal;

    // A pop only frees its credit once fifo_count_q has dropped, i.e. next cycle
    assign credits_used = {1'b0, inflight_q} + {1'b0, fifo_count_q};
    assign can_accept   = credits_used < (CNT_W+1)'(FIFO_DEPTH);

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (scan_sum >= (ID_W+1)'(NUM_REQ))
                scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
            if (!grant_any && bus.req_valid[scan_sum[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = scan_sum[ID_W-1:0];
            end
        end
    end

    // Gating with rst keeps req_ready low while reset is held
    assign handshake = grant_any && can_accept && !rst;
    assign grant_op  = req_op[grant_idx];
    assign grant_x   = req_x[grant_idx];

    always_comb begin
        req_ready_d = '0;
        if (handshake)
            req_ready_d[grant_idx] = 1'b1;
    end
    assign bus.req_ready = req_ready_d;

`ifdef SFU_OPCODE_CHECK_EN
    assign grant_illegal = grant_op > 4'd8;
`else
    assign grant_illegal = 1'b0;
`endif

    // ---------------- issue register ----------------
    logic             issue_valid_q;
    logic             issue_slot_q;   // a handshake happened, legal or not
    logic             issue_err_q;
    logic [ID_W-1:0]  issue_id_q;
    logic [3:0]       issue_opcode_q;
    logic [X_W-1:0]   issue_x_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q          <= '0;
            issue_valid_q  <= 1'b0;
            issue_slot_q   <= 1'b0;
            issue_err_q    <= 1'b0;
            issue_id_q     <= '0;
            issue_opcode_q <= '0;
            issue_x_q      <= '0;
        end else begin
            issue_slot_q  <= handshake;
            issue_valid_q <= handshake && !grant_illegal;
            if (handshake) begin
                ptr_q       <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
                issue_id_q  <= grant_idx;
                issue_err_q <= grant_illegal;
            end
            // Rejected ops never reach the datapath, so its operand bus holds
            if (handshake && !grant_illegal) begin
                issue_opcode_q <= grant_op;
                issue_x_q      <= grant_x;
            end
        end
    end

    assign bus.issue_valid  = issue_valid_q;
    assign bus.issue_opcode = issue_opcode_q;
    assign bus.issue_x      = issue_x_q;

    // ---------------- tracking pipe, output aligned with dp_valid ----------------
    logic            trk_valid_q [DP_LAT];
    logic            trk_err_q   [DP_LAT];
    logic [ID_W-1:0] trk_id_q    [DP_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < DP_LAT; s++) begin
                trk_valid_q[s] <= 1'b0;
                trk_err_q[s]   <= 1'b0;
                trk_id_q[s]    <= '0;
            end
        end else begin
            trk_valid_q[0] <= issue_slot_q;
            trk_err_q[0]   <= issue_err_q;
            trk_id_q[0]    <= issue_id_q;
            for (int s = 1; s < DP_LAT; s++) begin
                trk_valid_q[s] <= trk_valid_q[s-1];
                trk_err_q[s]   <= trk_err_q[s-1];
                trk_id_q[s]    <= trk_id_q[s-1];
            end
        end
    end

    logic            out_valid;
    logic            out_err;
    logic [ID_W-1:0] out_id;
    logic            push;
    logic            pop;
    logic [R_W-1:0]  push_data;

    assign out_valid = trk_valid_q[DP_LAT-1];
    assign out_err   = trk_err_q[DP_LAT-1];
    assign out_id    = trk_id_q[DP_LAT-1];
    // The tracked slot, not dp_valid, decides whether a response is produced
    assign push      = out_valid;
    assign push_data = out_err ? '0 : bus.dp_result;
    assign pop       = (fifo_count_q != '0) && bus.resp_ready;

    // ---------------- counters, mismatch flag, FIFO pointers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q     <= '0;
            fifo_count_q   <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            err_mismatch_q <= 1'b0;
        end else begin
            if (handshake && !push)
                inflight_q <= inflight_q + CNT_W'(1);
            else if (!handshake && push)
                inflight_q <= inflight_q - CNT_W'(1);

            if (push && !pop)
                fifo_count_q <= fifo_count_q + CNT_W'(1);
            else if (!push && pop)
                fifo_count_q <= fifo_count_q - CNT_W'(1);

            if (push)
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);

            if (bus.dp_valid != (out_valid && !out_err))
                err_mismatch_q <= 1'b1;
        end
    end

    // Storage array: entries are {id, data, err}; no reset needed, reads are
    // qualified by the occupancy count.
    logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [ENT_W-1:0] rd_word;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_q] <= {out_id, push_data, out_err};
    end

    assign rd_word = fifo_mem[rd_ptr_q];

    logic resp_valid_w;
    assign resp_valid_w     = fifo_count_q != '0;
    assign bus.resp_valid   = resp_valid_w;
    assign bus.resp_id      = resp_valid_w ? rd_word[ENT_W-1 -: ID_W] : '0;
    assign bus.resp_data    = resp_valid_w ? rd_word[R_W:1] : '0;
    assign bus.resp_err     = resp_valid_w && rd_word[0];
    assign bus.busy         = (inflight_q != '0) || resp_valid_w;
    assign bus.err_mismatch = err_mismatch_q;
endmodule

// File: tb/tb_sfu_op_scheduler.sv
module tb_sfu_op_scheduler;
    localparam int NUM_REQ    = 4;
    localparam int DP_LAT     = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int X_W        = 24;
    localparam int R_W        = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sfu_op_scheduler_if #(.NUM_REQ(NUM_REQ), .X_W(X_W), .R_W(R_W)) bus ();

    sfu_op_scheduler #(
        .NUM_REQ(NUM_REQ), .DP_LAT(DP_LAT), .FIFO_DEPTH(FIFO_DEPTH),
        .X_W(X_W), .R_W(R_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Datapath stand-in: fixed latency, result is a simple function of op/x
    function automatic logic [31:0] dp_func(input logic [3:0] op, input logic [23:0] x);
        return {op, 4'h0, x} ^ 32'h3F40_0000;
    endfunction

    logic        dp_v_sh [DP_LAT];
    logic [31:0] dp_r_sh [DP_LAT];
    logic        dp_force;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < DP_LAT; s++) begin
                dp_v_sh[s] <= 1'b0;
                dp_r_sh[s] <= '0;
            end
        end else begin
            dp_v_sh[0] <= bus.issue_valid;
            dp_r_sh[0] <= dp_func(bus.issue_opcode, bus.issue_x);
            for (int s = 1; s < DP_LAT; s++) begin
                dp_v_sh[s] <= dp_v_sh[s-1];
                dp_r_sh[s] <= dp_r_sh[s-1];
            end
        end
    end

    assign bus.dp_valid  = dp_v_sh[DP_LAT-1] | dp_force;
    assign bus.dp_result = dp_r_sh[DP_LAT-1];

    // Response monitor: records every pop, one line per transaction
    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
        logic        err;
    } resp_t;
    resp_t got_q[$];

    always begin
        @(negedge clk);
        #2;
        if (!rst && bus.resp_valid && bus.resp_ready) begin
            got_q.push_back({bus.resp_id, bus.resp_data, bus.resp_err});
            $display("resp id=%0d data=%h err=%b", bus.resp_id, bus.resp_data, bus.resp_err);
        end
    end

    task automatic set_req(input int port, input logic [3:0] op, input logic [23:0] x);
        bus.req_opcode[port*4 +: 4] = op;
        bus.req_x[port*X_W +: X_W]  = x;
    endtask

    task automatic wait_resps(input int n, input int budget, output bit ok);
        int c = 0;
        while (got_q.size() < n && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic test_reset();
        @(negedge clk);
        bus.req_valid  = 4'hF;
        bus.resp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
        checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b expected 0", bus.issue_valid); end
        checks++; if ({bus.issue_opcode, bus.issue_x} !== 28'h0) begin errors++; $display("FAIL reset_issue_bus: got %h expected 0", {bus.issue_opcode, bus.issue_x}); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
        checks++; if ({bus.resp_id, bus.resp_data, bus.resp_err} !== 35'h0) begin errors++; $display("FAIL reset_resp_bus: got %h expected 0", {bus.resp_id, bus.resp_data, bus.resp_err}); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.err_mismatch !== 1'b0) begin errors++; $display("FAIL reset_err_mismatch: got %b expected 0", bus.err_mismatch); end
        bus.req_valid = 4'h0;
        rst = 1'b0;
    endtask

    // All four ports request; with 4 credits and DP_LAT=3 the fifth grant
    // waits for the first pop.
    task automatic test_fairness();
        logic [3:0] exp_rdy [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
        logic [1:0] exp_id  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        bit ok;
        @(negedge clk);
        got_q.delete();
        bus.resp_ready = 1'b1;
        for (int g = 0; g < NUM_REQ; g++) set_req(g, 4'(g), 24'(24'h100000 * (g + 1)));
        bus.req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++; if (bus.req_ready !== exp_rdy[c]) begin errors++; $display("FAIL fair_grant_c%0d: got %b expected %b", c, bus.req_ready, exp_rdy[c]); end
            @(negedge clk);
        end
        bus.req_valid = 4'h0;
        wait_resps(6, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fair_resp_count: got %0d expected 6", got_q.size()); end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            logic [31:0] ed;
            ed = dp_func(4'(exp_id[i]), 24'(24'h100000 * (exp_id[i] + 1)));
            checks++;
            if (got_q[i].id !== exp_id[i] || got_q[i].data !== ed || got_q[i].err !== 1'b0) begin
                errors++; $display("FAIL fair_resp_%0d: got id=%0d data=%h expected id=%0d data=%h", i, got_q[i].id, got_q[i].data, exp_id[i], ed);
            end
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL fair_idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_single_op();
        @(negedge clk);
        got_q.delete();
        bus.resp_ready = 1'b1;
        set_req(2, 4'd0, 24'h400000);
        bus.req_valid = 4'b0100;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", bus.req_ready); end
        @(negedge clk); bus.req_valid = 4'b0000; #1;                      // T+1
        checks++; if (bus.issue_valid !== 1'b1) begin errors++; $display("FAIL single_issue_valid: got %b expected 1", bus.issue_valid); end
        checks++; if (bus.issue_x !== 24'h400000 || bus.issue_opcode !== 4'd0) begin errors++; $display("FAIL single_issue_bus: got op=%h x=%h expected op=0 x=400000", bus.issue_opcode, bus.issue_x); end
        @(negedge clk); #1;                                               // T+2
        checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL single_issue_drop: got %b expected 0", bus.issue_valid); end
        checks++; if (bus.issue_x !== 24'h400000) begin errors++; $display("FAIL single_issue_hold: got %h expected 400000", bus.issue_x); end
        @(negedge clk); #1;                                               // T+3
        @(negedge clk); #1;                                               // T+4
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL single_resp_early: got %b expected 0", bus.resp_valid); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
        @(negedge clk); #1;                                               // T+5
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL single_resp_valid: got %b expected 1", bus.resp_valid); end
        checks++; if (bus.resp_id !== 2'd2) begin errors++; $display("FAIL single_resp_id: got %0d expected 2", bus.resp_id); end
        checks++; if (bus.resp_data !== 32'h3F000000) begin errors++; $display("FAIL single_resp_data: got %h expected 3f000000", bus.resp_data); end
        checks++; if (bus.resp_err !== 1'b0) begin errors++; $display("FAIL single_resp_err: got %b expected 0", bus.resp_err); end
        @(negedge clk); #1;                                               // T+6
        checks++; if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL single_drain: got valid=%b busy=%b expected 0 0", bus.resp_valid, bus.busy); end
    endtask

    task automatic test_backpressure();
        int hs = 0;
        bit ok;
        @(negedge clk);
        got_q.delete();
        bus.resp_ready = 1'b0;
        set_req(0, 4'd3, 24'hA00000);
        bus.req_valid = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++; if (bus.req_ready[0] !== (c < 4)) begin errors++; $display("FAIL bp_stall_c%0d: got %b expected %b", c, bus.req_ready[0], (c < 4)); end
            if (bus.req_ready[0]) hs++;
            @(negedge clk);
            set_req(0, 4'd3, 24'(24'hA00000 + hs));
        end
        checks++; if (hs != 4) begin errors++; $display("FAIL bp_handshakes: got %0d expected 4", hs); end
        checks++; if (bus.resp_valid !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL bp_full: got valid=%b busy=%b expected 1 1", bus.resp_valid, bus.busy); end
        bus.resp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_same_cycle_credit: got %b expected 0", bus.req_ready[0]); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            set_req(0, 4'd3, 24'(24'hA00000 + hs));
            #1;
            checks++; if (bus.req_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_refill_c%0d: got %b expected 1", c, bus.req_ready[0]); end
            if (bus.req_ready[0]) hs++;
        end
        @(negedge clk);
        bus.req_valid = 4'b0000;
        wait_resps(6, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_resp_count: got %0d expected 6", got_q.size()); end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            logic [31:0] ed;
            ed = dp_func(4'd3, 24'(24'hA00000 + i));
            checks++;
            if (got_q[i].id !== 2'd0 || got_q[i].data !== ed) begin
                errors++; $display("FAIL bp_resp_%0d: got id=%0d data=%h expected id=0 data=%h", i, got_q[i].id, got_q[i].data, ed);
            end
        end
    endtask

    task automatic test_illegal_opcode();
        bit ok;
        resp_t exp_r [3];
        exp_r[0] = {2'd3, dp_func(4'd1, 24'h111111), 1'b0};
`ifdef SFU_OPCODE_CHECK_EN
        exp_r[1] = {2'd1, 32'h0, 1'b1};
`else
        exp_r[1] = {2'd1, dp_func(4'hA, 24'h222222), 1'b0};
`endif
        exp_r[2] = {2'd3, dp_func(4'd2, 24'h333333), 1'b0};
        @(negedge clk);
        got_q.delete();
        bus.resp_ready = 1'b1;
        set_req(3, 4'd1, 24'h111111);
        bus.req_valid = 4'b1000;
        #1;
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL ill_ready0: got %b expected 1000", bus.req_ready); end
        @(negedge clk);
        set_req(1, 4'hA, 24'h222222);
        bus.req_valid = 4'b0010;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL ill_ready1: got %b expected 0010", bus.req_ready); end
        checks++; if (bus.issue_valid !== 1'b1 || bus.issue_opcode !== 4'd1) begin errors++; $display("FAIL ill_issue0: got v=%b op=%h expected 1 1", bus.issue_valid, bus.issue_opcode); end
        @(negedge clk);
        set_req(3, 4'd2, 24'h333333);
        bus.req_valid = 4'b1000;
        #1;
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL ill_ready2: got %b expected 1000", bus.req_ready); end
`ifdef SFU_OPCODE_CHECK_EN
        checks++; if (bus.issue_valid !== 1'b0 || bus.issue_opcode !== 4'd1) begin errors++; $display("FAIL ill_issue1: got v=%b op=%h expected 0 1", bus.issue_valid, bus.issue_opcode); end
`else
        checks++; if (bus.issue_valid !== 1'b1 || bus.issue_opcode !== 4'hA) begin errors++; $display("FAIL ill_issue1: got v=%b op=%h expected 1 a", bus.issue_valid, bus.issue_opcode); end
`endif
        @(negedge clk);
        bus.req_valid = 4'b0000;
        #1;
        checks++; if (bus.issue_valid !== 1'b1 || bus.issue_x !== 24'h333333) begin errors++; $display("FAIL ill_issue2: got v=%b x=%h expected 1 333333", bus.issue_valid, bus.issue_x); end
        wait_resps(3, 30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ill_resp_count: got %0d expected 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_r[i]) begin
                errors++; $display("FAIL ill_resp_%0d: got id=%0d data=%h err=%b expected id=%0d data=%h err=%b", i, got_q[i].id, got_q[i].data, got_q[i].err, exp_r[i].id, exp_r[i].data, exp_r[i].err);
            end
        end
        checks++; if (bus.err_mismatch !== 1'b0) begin errors++; $display("FAIL ill_mismatch: got %b expected 0", bus.err_mismatch); end
    endtask

    task automatic test_mismatch();
        @(negedge clk);
        #1;
        checks++; if (bus.err_mismatch !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mm_pre: got mm=%b busy=%b expected 0 0", bus.err_mismatch, bus.busy); end
        dp_force = 1'b1;
        @(negedge clk);
        dp_force = 1'b0;
        #1;
        checks++; if (bus.err_mismatch !== 1'b1) begin errors++; $display("FAIL mm_set: got %b expected 1", bus.err_mismatch); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL mm_no_push: got %b expected 0", bus.resp_valid); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.err_mismatch !== 1'b1) begin errors++; $display("FAIL mm_sticky: got %b expected 1", bus.err_mismatch); end
    endtask

    // With 4 credits the deepest mid-flight state is 2 in the FIFO + 2 in flight
    task automatic test_reset_midflight();
        bit ok;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        set_req(0, 4'd4, 24'h0C0C0C);
        bus.req_valid = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rst_fill_c%0d: got %b expected 0001", c, bus.req_ready); end
            @(negedge clk);
        end
        bus.req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (bus.resp_valid !== 1'b1 || bus.busy !== 1'b1 || bus.err_mismatch !== 1'b1) begin errors++; $display("FAIL rst_pre: got valid=%b busy=%b mm=%b expected 1 1 1", bus.resp_valid, bus.busy, bus.err_mismatch); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_async_resp: got valid=%b busy=%b expected 0 0", bus.resp_valid, bus.busy); end
        checks++; if (bus.err_mismatch !== 1'b0) begin errors++; $display("FAIL rst_async_mm: got %b expected 0", bus.err_mismatch); end
        checks++; if (bus.issue_valid !== 1'b0 || bus.issue_x !== 24'h0 || bus.resp_data !== 32'h0) begin errors++; $display("FAIL rst_async_bus: got iv=%b ix=%h rd=%h expected 0", bus.issue_valid, bus.issue_x, bus.resp_data); end
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        bus.resp_ready = 1'b1;
        set_req(3, 4'd5, 24'h0ABCDE);
        bus.req_valid = 4'b1001;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rst_ptr_zero: got %b expected 0001", bus.req_ready); end
        bus.req_valid = 4'b1000;
        #1;
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL rst_port3_ready: got %b expected 1000", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 4'b0000;
        wait_resps(1, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_resp_count: got %0d expected 1", got_q.size()); end
        if (got_q.size() > 0) begin
            checks++;
            if (got_q[0] !== {2'd3, dp_func(4'd5, 24'h0ABCDE), 1'b0}) begin
                errors++; $display("FAIL rst_resp: got id=%0d data=%h err=%b expected id=3 data=%h err=0", got_q[0].id, got_q[0].data, got_q[0].err, dp_func(4'd5, 24'h0ABCDE));
            end
        end
        checks++; if (bus.err_mismatch !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_post_idle: got mm=%b busy=%b expected 0 0", bus.err_mismatch, bus.busy); end
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_opcode = '0;
        bus.req_x      = '0;
        bus.resp_ready = 1'b0;
        dp_force       = 1'b0;
        test_reset();
        test_fairness();
        test_single_op();
        test_backpressure();
        test_illegal_opcode();
        test_mismatch();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
